multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Moore FSM main control unit for the multicycle RISC-V datapath.
- Sequences fetch, decode and execute per instruction class; drives all datapath enables and the {ALUOp1, ALUOp0} pair that ALU_Control consumes.
- Supported instruction classes: R-type, ld, sd, beq.
- Sits between the instruction register (opcode field, ALU zero flag) and the datapath muxes/enables.

Parameters:
- OPC_R, 7'b0110011, R-type opcode
- OPC_LD, 7'b0000011, load doubleword opcode
- OPC_SD, 7'b0100011, store doubleword opcode
- OPC_BEQ, 7'b1100011, branch-equal opcode

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; sampled only in DECODE
- zero  in  1  ALU zero flag; used only in BRANCH
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 0=ALUOut, 1=MDR
- PCSource  out  1  PC source: 0=ALU result, 1=ALUOut
- ALUOp1  out  1  ALUOp MSB to ALU_Control
- ALUOp0  out  1  ALUOp LSB to ALU_Control
- ALUSrcA  out  1  ALU A select: 0=PC, 1=rs1
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- state  out  4  current state, debug only

Behaviour:
- Single clock; reset is synchronous and active-high.
- State register encoding: IDLE=15, FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8.
- reset=1 at a clock edge loads IDLE, overriding any other transition, including mid-instruction.
- IDLE: all outputs 0 (every output's reset value is 0). Next state: FETCH.
- Outputs are combinational from state only (pure Moore); signals not listed for a state are 0.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=0. Next: DECODE.
- DECODE: ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - OPC_LD or OPC_SD -> MEMADDR
  - OPC_R -> EXECUTE
  - OPC_BEQ -> BRANCH
  - any other opcode -> FETCH (treated as NOP; no write enables asserted; instr_done=0)
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMREAD if the latched class is ld, MEMWRITE if sd.
- MEMREAD: MemRead=1, IorD=1. Next: MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1. Next: FETCH.
- MEMWRITE: MemWrite=1, IorD=1, instr_done=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1. Next: FETCH. Taken/not-taken is resolved by the datapath via zero.
- Class latch: a 2-bit register captures the opcode class in DECODE, so opcode changes after DECODE have no effect. Reset value: ld.
- Instruction latency: R-type 4 cycles, ld 5, sd 4, beq 3, illegal opcode 2.
- Undefined state codes (9-14) -> next state FETCH, all outputs 0.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite and MemWrite are never both 1.
  - PCWrite and PCWriteCond are never both 1.

Decomposition:
- Shared package: state encodings, opcode constants, ALUOp codes (ADD=2'b00, SUB=2'b01, FUNCT=2'b10), ALUSrcB select codes.
- Natural sub-module: main_control_outdec, a combinational state-to-control-word decoder.
- The FSM top keeps the state register, class latch and next-state logic.

Test Plan:
- Reset: assert reset 2 cycles -> state=15, all outputs 0; deassert -> state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type: opcode=0110011 -> state sequence 0,1,6,7,0; ALUOp=10 only in state 6; RegWrite=1, MemtoReg=0 in state 7; instr_done pulses once.
- ld then sd:
  - opcode=0000011 -> 0,1,2,3,4,0; IorD=1 in state 3; RegWrite=1, MemtoReg=1 in state 4.
  - then opcode=0100011 -> 0,1,2,5,0; MemWrite=1 in state 5 only.
- beq: opcode=1100011, zero=1 -> 0,1,8,0; in state 8, ALUOp=01, PCWriteCond=1, PCSource=1. Repeat with zero=0 -> identical outputs.
- Illegal opcode 7'b1111111 -> 0,1,0; no RegWrite or MemWrite in any cycle; instr_done stays 0.
- Mid-operation reset and opcode change: during ld, assert reset in state 3 -> next state 15, outputs 0. Separately, change opcode in state 2 -> path still follows the class latched in DECODE.

Source files
------------

// File: rtl/multicycle_main_control_pkg.sv
// rtl/multicycle_main_control_pkg.sv - state, opcode, class and select encodings for the main control FSM
package multicycle_main_control_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IDLE     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CLS_LD  = 2'd0,
    CLS_SD  = 2'd1,
    CLS_R   = 2'd2,
    CLS_BEQ = 2'd3
  } cls_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_main_control_outdec.sv
// rtl/multicycle_main_control_outdec.sv - combinational state-to-control-word decoder
module multicycle_main_control_outdec
  import multicycle_main_control_pkg::*;
(
  input  logic [3:0] state,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       instr_done
);

  logic [1:0] alu_op;

  assign ALUOp1 = alu_op[1];
  assign ALUOp0 = alu_op[0];

  // Moore decode: every control is a function of the state alone; IDLE and unused codes leave everything low
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 1'b0;
    alu_op      = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        // PC + imm lands in ALUOut so BRANCH can use it as the target
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RS2;
        alu_op      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle RISC-V main control FSM (state register, class latch, next state)
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter logic [6:0] OPC_R_P   = OPC_R,
  parameter logic [6:0] OPC_LD_P  = OPC_LD,
  parameter logic [6:0] OPC_SD_P  = OPC_SD,
  parameter logic [6:0] OPC_BEQ_P = OPC_BEQ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       instr_done,
  output logic [3:0] state
);

  logic [3:0] state_r;
  state_t     next_state;
  cls_t       cls_r;
  cls_t       next_cls;

  // Branch resolution happens in the datapath (PCWriteCond & zero); the FSM never needs the flag
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_r;

  // State and class registers; reset overrides any transition, even mid-instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cls_r   <= CLS_LD;
    end else begin
      state_r <= next_state;
      cls_r   <= next_cls;
    end
  end

  // Next state; opcode is only looked at in DECODE, afterwards the latched class steers MEMADDR
  always_comb begin
    next_state = S_FETCH;
    next_cls   = cls_r;
    case (state_t'(state_r))
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_LD_P) begin
          next_state = S_MEMADDR;
          next_cls   = CLS_LD;
        end else if (opcode == OPC_SD_P) begin
          next_state = S_MEMADDR;
          next_cls   = CLS_SD;
        end else if (opcode == OPC_R_P) begin
          next_state = S_EXECUTE;
          next_cls   = CLS_R;
        end else if (opcode == OPC_BEQ_P) begin
          next_state = S_BRANCH;
          next_cls   = CLS_BEQ;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEMADDR: next_state = (cls_r == CLS_SD) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: next_state = S_MEMWB;
      S_EXECUTE: next_state = S_ALUWB;
      default:   next_state = S_FETCH;
    endcase
  end

  multicycle_main_control_outdec u_outdec (
    .state       (state_r),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .PCSource    (PCSource),
    .ALUOp1      (ALUOp1),
    .ALUOp0      (ALUOp0),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - scoreboard bench for the multicycle main control FSM
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, PCSource;
  logic       ALUOp1, ALUOp0, ALUSrcA, RegWrite, instr_done;
  logic [1:0] ALUSrcB;
  logic [3:0] state;

  multicycle_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .PCSource    (PCSource),
    .ALUOp1      (ALUOp1),
    .ALUOp0      (ALUOp0),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       done;
  } rec_t;

  rec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Expected observable word for one cycle spent in the given state number
  function automatic rec_t expect_for(input int st);
    rec_t r;
    r = '0;
    r.st = st[3:0];
    case (st)
      0: begin r.mem_read = 1; r.ir_write = 1; r.alu_src_b = 2'b01; r.pc_write = 1; end
      1: r.alu_src_b = 2'b10;
      2: begin r.alu_src_a = 1; r.alu_src_b = 2'b10; end
      3: begin r.mem_read = 1; r.iord = 1; end
      4: begin r.reg_write = 1; r.mem_to_reg = 1; r.done = 1; end
      5: begin r.mem_write = 1; r.iord = 1; r.done = 1; end
      6: begin r.alu_src_a = 1; r.alu_op = 2'b10; end
      7: begin r.reg_write = 1; r.done = 1; end
      8: begin r.alu_src_a = 1; r.alu_op = 2'b01; r.pc_write_cond = 1; r.pc_source = 1; r.done = 1; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  // Runs one instruction starting in the cycle that has just entered FETCH; abort_at (>=0) raises reset in that cycle
  task automatic run_instr(input logic [6:0] op, input logic z, input int abort_at);
    int sts[$];
    int n;
    case (op)
      7'b0000011: sts = '{0, 1, 2, 3, 4};
      7'b0100011: sts = '{0, 1, 2, 5};
      7'b0110011: sts = '{0, 1, 6, 7};
      7'b1100011: sts = '{0, 1, 8};
      default:    sts = '{0, 1};
    endcase
    n = sts.size();
    for (int i = 0; i < n; i++) begin
      if (abort_at < 0 || i <= abort_at) sb.push_back(expect_for(sts[i]));
    end
    if (abort_at >= 0 && abort_at < n) sb.push_back(expect_for(15));
    opcode = op;
    zero = z;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 2) begin
        opcode = 7'($urandom);
        zero = 1'($urandom);
      end
      if (c == abort_at) begin
        reset = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      reset = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one scoreboard entry per cycle, plus the structural invariants
  always @(negedge clk) begin
    rec_t e;
    rec_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, PCSource,
           ALUOp1, ALUOp0, ALUSrcA, ALUSrcB, RegWrite, instr_done};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_word t=%0t actual state=%0d ctl=%h required state=%0d ctl=%h",
                 $time, a.st, a[14:0], e.st, e[14:0]);
      end
      vectors++;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite) || (PCWrite && PCWriteCond)) begin
        miscompares++;
        $display("FAIL invariant t=%0t actual MR=%b MW=%b RW=%b PW=%b PWC=%b required no exclusive pair high",
                 $time, MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond);
      end
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout actual=still running required=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [6:0] op;
    int         k;
    int         ab;

    // Two reset cycles hold IDLE, then release into the first FETCH
    @(posedge clk); #1;
    sb.push_back(expect_for(15));
    @(posedge clk); #1;
    sb.push_back(expect_for(15));
    reset = 1'b0;
    @(posedge clk); #1;

    run_instr(7'b0110011, 1'b0, -1);
    run_instr(7'b0000011, 1'b0, -1);
    run_instr(7'b0100011, 1'b1, -1);
    run_instr(7'b1100011, 1'b1, -1);
    run_instr(7'b1100011, 1'b0, -1);
    run_instr(7'b1111111, 1'b0, -1);
    run_instr(7'b0000011, 1'b0, 3);
    run_instr(7'b0100011, 1'b0, -1);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: op = 7'b0110011;
        1: op = 7'b0000011;
        2: op = 7'b0100011;
        3: op = 7'b1100011;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, 1'($urandom), ab);
    end

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d entries left required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
